addition_normalize_pack_unit: RTL and testbench

Sequential stage-4 back end of the single-precision adder. It accepts the raw mantissa sum, the larger exponent, the result sign and the leading-one position from the addition control unit, then normalises iteratively, one bit per cycle. It packs the IEEE-754 word and flags overflow and underflow. It sits between the mantissa adder and the adder top, with a valid/ready handshake toward the control path.

---
 rtl/fp_add_pkg.sv | 21 ++
 rtl/addition_normalize_pack_unit.sv | 168 ++++++++++++++++
 tb/tb_addition_normalize_pack_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared definitions for the single-precision adder pipeline: default widths,
// exponent limits, the back-end state encoding and the shift-count width.
package fp_add_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int MENT_WIDTH_DEF = 23;
   localparam int EXPO_WIDTH_DEF = 8;

   localparam logic [7:0] EXP_MAX      = 8'hFF;
   localparam logic [7:0] EXP_MIN_NORM = 8'h01;

   // Enough bits to hold a leading-one index 0..MENT_WIDTH and a shift count.
   localparam int SHIFT_WIDTH = $clog2(MENT_WIDTH_DEF) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      PACK = 2'd2
   } norm_state_e;

endpackage : fp_add_pkg

// File: rtl/addition_normalize_pack_unit.sv
// Stage-4 back end of the single-precision adder: captures the raw mantissa
// sum, normalises it left one bit per cycle, then packs the IEEE-754 word with
// overflow (to infinity) and underflow (flush to zero) handling. Truncating.
module addition_normalize_pack_unit
   import fp_add_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MENT_WIDTH = MENT_WIDTH_DEF,
   parameter int EXPO_WIDTH = EXPO_WIDTH_DEF
) (
   input  logic                          clk_in,
   input  logic                          rstn_in,
   input  logic                          start_in,
   output logic                          ready_out,
   input  logic                          sign_in,
   input  logic [EXPO_WIDTH-1:0]         exponent_in,
   input  logic [MENT_WIDTH+1:0]         sum_in,
   input  logic [$clog2(MENT_WIDTH):0]   normalize_position_in,
   output logic [DATA_WIDTH-1:0]         result_out,
   output logic                          done_out,
   output logic                          overflow_out,
   output logic                          underflow_out
);

   localparam int SW = $clog2(MENT_WIDTH) + 1;

   norm_state_e               state_q, state_d;
   logic                      sign_q, sign_d;
   logic [EXPO_WIDTH-1:0]     exp_q, exp_d;
   logic [MENT_WIDTH:0]       mant_q, mant_d;
   logic [SW-1:0]             cnt_q, cnt_d;
   logic                      zero_q, zero_d;
   logic                      ovf_q, ovf_d;
   logic                      unf_q, unf_d;
   logic [DATA_WIDTH-1:0]     result_q, result_d;
   logic                      done_q, done_d;
   logic                      ovf_out_q, ovf_out_d;
   logic                      unf_out_q, unf_out_d;

   logic                      carry_s;
   logic                      sum_zero_s;
   logic                      ovf_in_s;

   // Operand classification used on the accept edge.
   always_comb begin
      carry_s    = sum_in[MENT_WIDTH+1];
      sum_zero_s = (sum_in == '0);
      // A carry bumps the exponent, so EXP_MAX-1 with carry also overflows.
      ovf_in_s   = (exponent_in == EXP_MAX) ||
                   (carry_s && (exponent_in == (EXP_MAX - EXP_MIN_NORM)));
   end

   // Next-state and datapath: capture in IDLE, shift in NORM, pack in PACK.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      mant_d    = mant_q;
      cnt_d     = cnt_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      result_d  = result_q;
      done_d    = 1'b0;
      ovf_out_d = ovf_out_q;
      unf_out_d = unf_out_q;

      case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d = NORM;
               sign_d  = sum_zero_s ? 1'b0 : sign_in;
               zero_d  = sum_zero_s;
               ovf_d   = ovf_in_s;
               unf_d   = 1'b0;
               if (carry_s) begin
                  mant_d = sum_in[MENT_WIDTH+1:1];
                  exp_d  = exponent_in + {{(EXPO_WIDTH-1){1'b0}}, 1'b1};
                  cnt_d  = '0;
               end else begin
                  mant_d = sum_in[MENT_WIDTH:0];
                  exp_d  = exponent_in;
                  // Leading-one position is trusted as supplied.
                  if (sum_zero_s || ovf_in_s) begin
                     cnt_d = '0;
                  end else begin
                     cnt_d = SW'(MENT_WIDTH) - normalize_position_in;
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end

         NORM: begin
            if (cnt_q == '0) begin
               state_d = PACK;
            end else if (exp_q > EXP_MIN_NORM) begin
               mant_d = {mant_q[MENT_WIDTH-1:0], 1'b0};
               exp_d  = exp_q - {{(EXPO_WIDTH-1){1'b0}}, 1'b1};
               cnt_d  = cnt_q - {{(SW-1){1'b0}}, 1'b1};
            end else begin
               // Further shifts would leave the normal range: flush to zero.
               unf_d   = 1'b1;
               state_d = PACK;
            end
         end

         PACK: begin
            state_d   = IDLE;
            done_d    = 1'b1;
            ovf_out_d = ovf_q;
            unf_out_d = unf_q;
            if (ovf_q) begin
               result_d = {sign_q, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
            end else if (unf_q) begin
               result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
            end else if (zero_q) begin
               result_d = '0;
            end else begin
               result_d = {sign_q, exp_q, mant_q[MENT_WIDTH-1:0]};
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset clears everything.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q   <= IDLE;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         mant_q    <= '0;
         cnt_q     <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         result_q  <= '0;
         done_q    <= 1'b0;
         ovf_out_q <= 1'b0;
         unf_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         mant_q    <= mant_d;
         cnt_q     <= cnt_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         result_q  <= result_d;
         done_q    <= done_d;
         ovf_out_q <= ovf_out_d;
         unf_out_q <= unf_out_d;
      end
   end

   assign ready_out     = (state_q == IDLE);
   assign result_out    = result_q;
   assign done_out      = done_q;
   assign overflow_out  = ovf_out_q;
   assign underflow_out = unf_out_q;

endmodule : addition_normalize_pack_unit

// File: tb/tb_addition_normalize_pack_unit.sv
// Self-checking bench: directed cases plus randomized operands compared with
// an arithmetic reference model of normalise-and-pack.
module tb_addition_normalize_pack_unit;

   logic        clk_in;
   logic        rstn_in;
   logic        start_in;
   logic        ready_out;
   logic        sign_in;
   logic [7:0]  exponent_in;
   logic [24:0] sum_in;
   logic [5:0]  normalize_position_in;
   logic [31:0] result_out;
   logic        done_out;
   logic        overflow_out;
   logic        underflow_out;

   int n_total = 0;
   int n_pass  = 0;
   logic [31:0] prev_result = 32'h0;

   addition_normalize_pack_unit dut (
      .clk_in                (clk_in),
      .rstn_in               (rstn_in),
      .start_in              (start_in),
      .ready_out             (ready_out),
      .sign_in               (sign_in),
      .exponent_in           (exponent_in),
      .sum_in                (sum_in),
      .normalize_position_in (normalize_position_in),
      .result_out            (result_out),
      .done_out              (done_out),
      .overflow_out          (overflow_out),
      .underflow_out         (underflow_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      if (obs === expv) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   // Reference: what the finished float should be, from the arithmetic rules.
   task automatic ref_model(input logic s, input logic [7:0] e, input logic [24:0] sm,
                            input logic [5:0] p, output logic [31:0] res,
                            output logic ovf, output logic unf, output int lat);
      int k;
      logic [23:0] m;
      ovf = (e == 8'd255) || (sm[24] && (e == 8'd254));
      unf = 1'b0;
      lat = 2;
      if (ovf) begin
         res = {((sm == 25'd0) ? 1'b0 : s), 8'hFF, 23'h0};
      end else if (sm == 25'd0) begin
         res = 32'h0;
      end else if (sm[24]) begin
         res = {s, e + 8'd1, sm[23:1]};
      end else begin
         k = 23 - int'(p);
         if (int'(e) - 1 >= k) begin
            m   = sm[23:0] << k;
            res = {s, 8'(int'(e) - k), m[22:0]};
            lat = k + 2;
         end else begin
            unf = 1'b1;
            res = {s, 31'h0};
            lat = (int'(e) - 1) + 2;
         end
      end
   endtask

   function automatic logic [5:0] lead_pos(input logic [24:0] sm);
      logic [5:0] p;
      p = 6'd0;
      for (int i = 0; i < 24; i++) begin
         if (sm[i]) p = 6'(i);
      end
      return p;
   endfunction

   // Runs one operation from accept to done; called right after a sample point.
   task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] sm,
                         input logic [5:0] p, input bit inject);
      logic [31:0] exp_res;
      logic        exp_ovf, exp_unf;
      int          exp_lat, n;
      bit          seen, ready_bad;
      ref_model(s, e, sm, p, exp_res, exp_ovf, exp_unf, exp_lat);
      check_val("ready_before", 32'(ready_out), 32'h1);
      sign_in = s; exponent_in = e; sum_in = sm; normalize_position_in = p;
      start_in = 1'b1;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      ready_bad = 1'b0;
      seen = 1'b0;
      n = 0;
      check_val("result_hold", result_out, prev_result);
      while (!seen && n < 40) begin
         if (!done_out && ready_out) ready_bad = 1'b1;
         if (inject && n == 3) begin
            start_in = 1'b1; sign_in = ~s; exponent_in = 8'd3; sum_in = 25'h1FFFFFF;
            normalize_position_in = 6'd23;
         end else begin
            start_in = 1'b0;
         end
         @(posedge clk_in);
         #1;
         n++;
         if (done_out) seen = 1'b1;
      end
      start_in = 1'b0;
      if (!seen) begin
         check_val("timeout", 32'h0, 32'h1);
      end else begin
         check_val("result", result_out, exp_res);
         check_val("overflow", 32'(overflow_out), 32'(exp_ovf));
         check_val("underflow", 32'(underflow_out), 32'(exp_unf));
         check_val("latency", 32'(n), 32'(exp_lat));
         check_val("ready_low", 32'(ready_bad), 32'h0);
         check_val("ready_on_done", 32'(ready_out), 32'h1);
         prev_result = exp_res;
      end
   endtask

   initial begin
      logic [24:0] sm;
      logic [7:0]  e;
      int          cls, p;
      bit          spurious;

      rstn_in = 1'b0; start_in = 1'b0; sign_in = 1'b0; exponent_in = 8'd0;
      sum_in = 25'd0; normalize_position_in = 6'd0;
      #12;
      check_val("rst_result", result_out, 32'h0);
      check_val("rst_done", 32'(done_out), 32'h0);
      check_val("rst_ready", 32'(ready_out), 32'h1);
      check_val("rst_flags", {30'h0, overflow_out, underflow_out}, 32'h0);
      @(negedge clk_in);
      rstn_in = 1'b1;
      @(posedge clk_in);
      #1;

      // Directed cases; consecutive calls are back-to-back on the done cycle.
      run_op(1'b0, 8'd127, 25'h1000000, 6'd0, 1'b0);
      run_op(1'b0, 8'd127, 25'h0C00000, 6'd23, 1'b0);
      run_op(1'b0, 8'd127, 25'h0000001, 6'd0, 1'b1);
      run_op(1'b1, 8'd10, 25'h0000001, 6'd0, 1'b0);
      run_op(1'b0, 8'd254, 25'h1000000, 6'd0, 1'b0);
      run_op(1'b1, 8'd100, 25'h0000000, 6'd0, 1'b0);
      run_op(1'b1, 8'd255, 25'h0400000, 6'd22, 1'b0);
      run_op(1'b0, 8'd1, 25'h0000100, 6'd8, 1'b0);

      // Randomized operands.
      for (int t = 0; t < 40; t++) begin
         cls = int'($urandom_range(0, 9));
         e   = 8'($urandom_range(1, 255));
         if (cls == 0) begin
            sm = 25'd0;
         end else if (cls <= 2) begin
            sm = 25'h1000000 | (25'($urandom) & 25'hFFFFFF);
            if (cls == 2) e = 8'd254;
         end else begin
            p  = int'($urandom_range(0, 23));
            sm = (25'd1 << p) | (25'($urandom) & ((25'd1 << p) - 25'd1));
            if (cls == 3) e = 8'($urandom_range(1, 30));
         end
         run_op(1'($urandom_range(0, 1)), e, sm, lead_pos(sm), 1'b0);
         if ((t % 7) == 3) begin
            repeat (2) @(posedge clk_in);
            #1;
         end
      end

      // Reset five cycles into a 23-shift operation.
      sign_in = 1'b0; exponent_in = 8'd127; sum_in = 25'h0000001; normalize_position_in = 6'd0;
      start_in = 1'b1;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      repeat (5) @(posedge clk_in);
      #1;
      rstn_in = 1'b0;
      #1;
      check_val("abort_result", result_out, 32'h0);
      check_val("abort_done", 32'(done_out), 32'h0);
      check_val("abort_ready", 32'(ready_out), 32'h1);
      check_val("abort_flags", {30'h0, overflow_out, underflow_out}, 32'h0);
      @(negedge clk_in);
      rstn_in = 1'b1;
      spurious = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk_in);
         #1;
         if (done_out) spurious = 1'b1;
      end
      check_val("abort_no_done", 32'(spurious), 32'h0);
      prev_result = 32'h0;
      run_op(1'b1, 8'd127, 25'h0800000, 6'd23, 1'b0);
      run_op(1'b0, 8'd150, 25'h0000013, 6'd4, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_addition_normalize_pack_unit
